// File: rtl/fp32_postnormaliser_if.sv
// Handshake and data bundle between the FP32 adder core and its post-normaliser.
// The master drives operands and out_ready. The slave returns ready, the result and diagnostics.
interface fp32_postnormaliser_if;
    logic        in_valid;
    logic        in_ready;
    logic        legal;
    logic        NaN_res;
    logic        inf_res;
    logic        res_sig;
    logic [7:0]  exp_max;
    logic [50:0] mant_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [5:0]  norm_cycles;

    modport master (
        output in_valid, legal, NaN_res, inf_res, res_sig, exp_max, mant_sum, out_ready,
        input  in_ready, out_valid, result, norm_cycles
    );

    modport slave (
        input  in_valid, legal, NaN_res, inf_res, res_sig, exp_max, mant_sum, out_ready,
        output in_ready, out_valid, result, norm_cycles
    );
endinterface

// File: rtl/fp32_postnormaliser.sv
// FP32 adder back end: iterative normalise (up to LZ_STEP bits/cycle), round-to-nearest-even, pack.
// Latency: 1 cycle for specials/zero, NORM cycles + 2 otherwise. One op in flight; result held until out_ready.
module fp32_postnormaliser #(
    parameter int          LZ_STEP     = 4,
    parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp32_postnormaliser_if.slave bus
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic [50:0] m_q, m_d;
    logic [9:0]  e_q, e_d;
    logic        s_q, s_d;
    logic [31:0] result_q, result_d;
    logic [5:0]  nc_q, nc_d;

    logic [9:0]  lz_w;
    logic [9:0]  k_w;
    logic        rinc_w;
    logic [24:0] rsum_w;
    logic [9:0]  er_w;
    logic        hidden_w;
    logic [22:0] frac_w;

    // Distance from the leading one down to the hidden-bit position.
    always_comb begin
        lz_w = '0;
        for (int i = 0; i < 50; i++) begin
            if (m_q[i]) lz_w = 10'(49 - i);
        end
    end

    always_comb begin
        k_w = lz_w;
        if (k_w > 10'(LZ_STEP)) k_w = 10'(LZ_STEP);
        if (k_w > e_q - 10'd1)  k_w = e_q - 10'd1;
    end

    // A carry out of the 24-bit significand means 2.0: renormalise to 1.0 with e+1.
    always_comb begin
        rinc_w   = m_q[25] & ((|m_q[24:0]) | m_q[26]);
        rsum_w   = {1'b0, m_q[49:26]} + {24'd0, rinc_w};
        er_w     = e_q + {9'd0, rsum_w[24]};
        hidden_w = rsum_w[24] | rsum_w[23];
        frac_w   = rsum_w[24] ? 23'd0 : rsum_w[22:0];
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        e_d      = e_q;
        s_d      = s_q;
        result_d = result_q;
        nc_d     = nc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d  = bus.mant_sum;
                    e_d  = (bus.exp_max == 8'd0) ? 10'd1 : {2'b00, bus.exp_max};
                    s_d  = bus.res_sig;
                    nc_d = '0;
                    if (!bus.legal) begin
                        state_d = DONE;
                        if (bus.NaN_res)      result_d = NAN_PATTERN;
                        else if (bus.inf_res) result_d = {bus.res_sig, 8'hFF, 23'h0};
                        else                  result_d = {bus.res_sig, 31'h0};
                    end else if (bus.mant_sum == 51'd0) begin
                        state_d  = DONE;
                        result_d = {bus.res_sig, 31'h0};
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                nc_d = (nc_q == 6'd63) ? nc_q : nc_q + 6'd1;
                if (m_q[50]) begin
                    m_d     = {1'b0, m_q[50:2], m_q[1] | m_q[0]};
                    e_d     = e_q + 10'd1;
                    state_d = ROUND;
                end else if (m_q[49] || e_q == 10'd1) begin
                    state_d = ROUND;
                end else begin
                    m_d = m_q << k_w;
                    e_d = e_q - k_w;
                end
            end
            ROUND: begin
                e_d     = er_w;
                state_d = DONE;
                if (er_w >= 10'd255)
                    result_d = {s_q, 8'hFF, 23'h0};
                else
                    result_d = {s_q, hidden_w ? er_w[7:0] : 8'd0, frac_w};
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            m_q      <= '0;
            e_q      <= '0;
            s_q      <= 1'b0;
            result_q <= '0;
            nc_q     <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            e_q      <= e_d;
            s_q      <= s_d;
            result_q <= result_d;
            nc_q     <= nc_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.norm_cycles = nc_q;

endmodule
